// File: rtl/tpu_pkg.sv
// tpu_pkg: constants, state encoding and index helper shared by the systolic array blocks.
package tpu_pkg;
  localparam int MAX_N = 256;
  localparam int LOG2_MAX_N = 8;
  localparam int DEF_OP_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 32;
  typedef enum logic {IDLE, SEND} drain_state_e;
  function automatic int elem_offset(input int r, input int c, input int n);
    return r * n + c;
  endfunction
endpackage

// File: rtl/shift_saturate.sv
// shift_saturate: arithmetic right shift of a signed accumulator, then saturation to OUT_WIDTH.
module shift_saturate #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_WIDTH-1:0] in_i,
  output logic        [OUT_WIDTH-1:0] out_o
);
  logic signed [ACC_WIDTH-1:0] s;
  logic fits;
  assign s = in_i >>> SHIFT;
  // The value fits when every bit from the output sign bit upward matches.
  assign fits = &s[ACC_WIDTH-1:OUT_WIDTH-1] || ~|s[ACC_WIDTH-1:OUT_WIDTH-1];
  assign out_o = fits ? s[OUT_WIDTH-1:0] : {s[ACC_WIDTH-1], {(OUT_WIDTH-1){~s[ACC_WIDTH-1]}}};
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the MAC accumulator array on done and streams it out row-major.
module systolic_result_drain
  import tpu_pkg::*;
#(
  parameter int N = 2,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done,
  input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LOG2_MAX_N-1:0]      out_row,
  output logic [LOG2_MAX_N-1:0]      out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       drain_done,
  output logic                       overrun
);
  localparam logic [LOG2_MAX_N-1:0] LAST = LOG2_MAX_N'(N - 1);
  localparam int IW = $clog2(N * N * ACC_WIDTH);
  drain_state_e state_q, state_d;
  logic [N*N*ACC_WIDTH-1:0] snap_q;
  logic [LOG2_MAX_N-1:0] row_q, row_d, col_q, col_d;
  logic done_q, overrun_q, overrun_d, drain_done_q, drain_done_d;
  logic done_rise, hs, last, load;
  logic [IW-1:0] base;
  logic [OUT_WIDTH-1:0] conv;
  assign done_rise = done && !done_q;
  assign out_valid = state_q == SEND;
  assign busy = out_valid;
  assign hs = out_valid && out_ready;
  assign last = row_q == LAST && col_q == LAST;
  assign out_last = last && out_valid;
  assign out_row = row_q;
  assign out_col = col_q;
  assign out_data = out_valid ? conv : '0;
  assign drain_done = drain_done_q;
  assign overrun = overrun_q;
  assign base = IW'(ACC_WIDTH * elem_offset(int'(row_q), int'(col_q), N));
  shift_saturate #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_conv (
    .in_i  (snap_q[base +: ACC_WIDTH]),
    .out_o (conv)
  );
  // A done rise while streaming never recaptures; it only flags the overrun.
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    drain_done_d = 1'b0;
    overrun_d = overrun_q || (done_rise && state_q == SEND);
    load = state_q == IDLE && done_rise;
    if (load) begin
      state_d = SEND;
      row_d = '0;
      col_d = '0;
    end else if (hs) begin
      state_d = last ? IDLE : SEND;
      drain_done_d = last;
      col_d = col_q == LAST ? '0 : col_q + 1'b1;
      row_d = last ? '0 : (col_q == LAST ? row_q + 1'b1 : row_q);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q <= '0;
      row_q <= '0;
      col_q <= '0;
      done_q <= 1'b0;
      overrun_q <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      done_q <= done;
      overrun_q <= overrun_d;
      drain_done_q <= drain_done_d;
      if (load) snap_q <= acc_in;
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: directed checks of the drain for N=2 (two shifts), N=1 and N=4.
module tb_systolic_result_drain;
  logic clk = 1'b0;
  logic reset, done, ready;
  logic [4*32-1:0] acc2;
  logic [31:0] acc1;
  logic [16*32-1:0] acc4;
  logic [7:0] d[4], r[4], c[4];
  logic v[4], l[4], b[4], dd[4], ov[4];
  int checks = 0, errors = 0;
  logic [7:0] e1[4] = '{8'h05, 8'hFD, 8'h64, 8'h07};

  always #5 clk = ~clk;

  systolic_result_drain #(.N(2), .SHIFT(0)) u_dut (.clk(clk), .reset(reset), .done(done), .acc_in(acc2),
    .out_data(d[0]), .out_valid(v[0]), .out_ready(ready), .out_row(r[0]), .out_col(c[0]), .out_last(l[0]),
    .busy(b[0]), .drain_done(dd[0]), .overrun(ov[0]));
  systolic_result_drain #(.N(2), .SHIFT(2)) u_shift (.clk(clk), .reset(reset), .done(done), .acc_in(acc2),
    .out_data(d[1]), .out_valid(v[1]), .out_ready(ready), .out_row(r[1]), .out_col(c[1]), .out_last(l[1]),
    .busy(b[1]), .drain_done(dd[1]), .overrun(ov[1]));
  systolic_result_drain #(.N(1)) u_n1 (.clk(clk), .reset(reset), .done(done), .acc_in(acc1),
    .out_data(d[2]), .out_valid(v[2]), .out_ready(ready), .out_row(r[2]), .out_col(c[2]), .out_last(l[2]),
    .busy(b[2]), .drain_done(dd[2]), .overrun(ov[2]));
  systolic_result_drain #(.N(4)) u_n4 (.clk(clk), .reset(reset), .done(done), .acc_in(acc4),
    .out_data(d[3]), .out_valid(v[3]), .out_ready(ready), .out_row(r[3]), .out_col(c[3]), .out_last(l[3]),
    .busy(b[3]), .drain_done(dd[3]), .overrun(ov[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_el(input int i, input logic [7:0] ed, input int k, input int n);
    chk("valid", 32'(v[i]), 1);
    chk("data", 32'(d[i]), 32'(ed));
    chk("row", 32'(r[i]), k / n);
    chk("col", 32'(c[i]), k % n);
    chk("last", 32'(l[i]), 32'(k == n * n - 1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(d[0]), 0);
    chk({tag, "_valid"}, 32'(v[0]), 0);
    chk({tag, "_row"}, 32'(r[0]), 0);
    chk({tag, "_col"}, 32'(c[0]), 0);
    chk({tag, "_last"}, 32'(l[0]), 0);
    chk({tag, "_busy"}, 32'(b[0]), 0);
    chk({tag, "_drain_done"}, 32'(dd[0]), 0);
    chk({tag, "_overrun"}, 32'(ov[0]), 0);
  endtask

  initial begin
    int n, vcnt;
    logic [7:0] s0[4], s2[4];
    reset = 1'b1; done = 1'b0; ready = 1'b0;
    acc2 = '0; acc1 = '0; acc4 = '0;
    step(); step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    // basic drain, done then held high
    acc2 = {32'sd7, 32'sd100, -32'sd3, 32'sd5};
    ready = 1'b1; done = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk_el(0, e1[k], k, 2);
      step();
    end
    chk("end_valid", 32'(v[0]), 0);
    chk("end_drain_done", 32'(dd[0]), 1);
    step();
    chk("drain_done_pulse", 32'(dd[0]), 0);
    vcnt = 0;
    for (int k = 0; k < 18; k++) begin
      vcnt += int'(v[0]);
      step();
    end
    chk("held_done_no_redrain", 32'(vcnt), 0);
    // saturation, SHIFT=0 and SHIFT=2
    done = 1'b0;
    acc2 = {-32'sd128, 32'sd127, -32'sd1000, 32'sd200};
    s0 = '{8'h7F, 8'h80, 8'h7F, 8'h80};
    s2 = '{8'h32, 8'h80, 8'h1F, 8'hE0};
    step();
    done = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk_el(0, s0[k], k, 2);
      chk_el(1, s2[k], k, 2);
      step();
    end
    // backpressure with ready pattern 1,0,0,1
    done = 1'b0;
    acc2 = {32'sd7, 32'sd100, -32'sd3, 32'sd5};
    step();
    done = 1'b1;
    step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      if (v[0]) begin
        chk_el(0, e1[n], n, 2);
        if (ready) n++;
      end
      step();
    end
    chk("bp_handshakes", 32'(n), 4);
    chk("bp_idle", 32'(v[0]), 0);
    // overrun mid-stream; snapshot must survive acc_in changes
    done = 1'b0; ready = 1'b0;
    step();
    done = 1'b1;
    step();
    chk_el(0, e1[0], 0, 2);
    chk("no_overrun_yet", 32'(ov[0]), 0);
    done = 1'b0;
    step();
    done = 1'b1;
    acc2 = {4{32'h11}};
    step();
    chk("overrun_set", 32'(ov[0]), 1);
    chk_el(0, e1[0], 0, 2);
    ready = 1'b1;
    step();
    for (int k = 1; k < 4; k++) begin
      chk_el(0, e1[k], k, 2);
      step();
    end
    chk("ovr_drain_done", 32'(dd[0]), 1);
    chk("overrun_sticky", 32'(ov[0]), 1);
    // reset after two handshakes, then a full fresh drain
    done = 1'b0;
    acc2 = {32'sd7, 32'sd100, -32'sd3, 32'sd5};
    step();
    done = 1'b1;
    step(); step(); step();
    chk_el(0, e1[2], 2, 2);
    reset = 1'b1; done = 1'b0;
    step();
    chk_zero("midreset");
    reset = 1'b0;
    step();
    done = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk_el(0, e1[k], k, 2);
      step();
    end
    chk("rst_drain_done", 32'(dd[0]), 1);
    // N=1 and N=4
    repeat (20) step();
    done = 1'b0;
    acc1 = -32'sd7;
    for (int k = 0; k < 16; k++) acc4[k*32 +: 32] = 32'(k);
    step();
    done = 1'b1;
    step();
    chk_el(2, 8'hF9, 0, 1);
    for (int k = 0; k < 16; k++) begin
      chk_el(3, 8'(k), k, 4);
      step();
      if (k == 0) begin
        chk("n1_valid_off", 32'(v[2]), 0);
        chk("n1_drain_done", 32'(dd[2]), 1);
      end
    end
    chk("n4_drain_done", 32'(dd[3]), 1);
    chk("n4_idle", 32'(v[3]), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Downstream stage of the systolic matrix multiplier. When the multiplier signals completion, this block snapshots the N×N accumulator array from the MAC grid. It then streams the elements out in row-major order over a valid/ready interface. Each element is arithmetically right-shifted and saturated to the output width, so results can be written back into operand memory for the next layer.

Parameters:
N, 2, matrix dimension (N×N results); legal range 1..MAX_N
MAX_N, 256, largest supported N
LOG2_MAX_N, 8, index width for row/col counters
ACC_WIDTH, 32, accumulator width, signed two's complement
OUT_WIDTH, 8, output element width, signed two's complement; OUT_WIDTH ≤ ACC_WIDTH
SHIFT, 0, arithmetic right shift applied before saturation; 0..ACC_WIDTH-1

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
done  in  1  level from multiplier; high once its state counter reaches 3N-1
acc_in  in  N*N*ACC_WIDTH  accumulator array; element (r,c) at bits [ACC_WIDTH*(r*N+c) +: ACC_WIDTH]
out_data  out  OUT_WIDTH  shifted, saturated element
out_valid  out  1  out_data/out_row/out_col/out_last are valid
out_ready  in  1  consumer accepts the element when out_valid && out_ready
out_row  out  LOG2_MAX_N  row index of the current element
out_col  out  LOG2_MAX_N  column index of the current element
out_last  out  1  high with element (N-1,N-1)
busy  out  1  high in SEND
drain_done  out  1  one-cycle pulse after the last handshake
overrun  out  1  sticky; a new done rising edge arrived while busy

Behaviour:
- Reset values: out_data=0, out_valid=0, out_row=0, out_col=0, out_last=0, busy=0, drain_done=0, overrun=0. Internal done_d=0, so a done that is already high right after reset counts as a rising edge.
- Reset mid-stream aborts the drain immediately. No partial state remains; the next done rise starts again from element 0.
- Rising-edge detection: done_rise = done && !done_d. done_d is registered every cycle. A level-held done therefore triggers only one drain.
- FSM states:
  - IDLE: on done_rise at edge k, capture acc_in into an N*N*ACC_WIDTH snapshot register, set index=0, go to SEND. From edge k onward: out_valid=1, out_row=0, out_col=0, out_data=conv(elem 0). Latency from done rise to first valid is one edge.
  - SEND: on a handshake (out_valid && out_ready), advance the index. col wraps N-1→0 and increments row. Outputs update to the next element at the same edge.
    - If the handshaked element is the last one, go to IDLE: out_valid=0, busy=0, drain_done=1 for one cycle, row/col reset to 0.
    - With no handshake, all outputs hold stable. out_valid never drops without a handshake.
- done_rise while in SEND: ignored for data, overrun is set. The snapshot is not overwritten.
- Simultaneous last handshake and done_rise at the same edge: treated as in SEND (overrun=1), and no new capture occurs.
- out_ready may be high or low in any state. It is ignored when out_valid=0.
- conv(x):
  - s = x >>> SHIFT (sign-preserving).
  - If s > 2^(OUT_WIDTH-1)-1, output the maximum positive value. If s < -2^(OUT_WIDTH-1), output the minimum negative value. Otherwise output s[OUT_WIDTH-1:0].
  - When OUT_WIDTH == ACC_WIDTH, saturation is a no-op.
- out_last = (row==N-1 && col==N-1) && out_valid.
- N=1 case: a single element with out_last=1 on it.
- Throughput: with out_ready held high, one element per cycle; N*N cycles from first valid to drain_done.

Decomposition:
- Shared package tpu_pkg holds:
  - MAX_N and LOG2_MAX_N constants, shared with the multiplier;
  - the default OP_WIDTH/ACC_WIDTH;
  - a state enum for IDLE/SEND;
  - a function computing the flat element offset r*N+c.
- One sub-module, shift_saturate: a combinational ACC_WIDTH→OUT_WIDTH converter with a SHIFT parameter. It is reused later for the multiplier's write-back path.
- FSM, counters, snapshot register and handshake live in systolic_result_drain.

Test Plan:
- Basic drain. Setup: N=2, SHIFT=0, OUT_WIDTH=8, acc_in={(0,0)=5,(0,1)=-3,(1,0)=100,(1,1)=7}, out_ready=1, done raised. Required: out_data 5, 0xFD, 100, 7 on four consecutive cycles; (row,col) = (0,0),(0,1),(1,0),(1,1); out_last only on the 4th; drain_done one cycle later.
- Saturation and shift. Setup: acc_in={200,-1000,127,-128}, SHIFT=0. Required: out_data 127, -128, 127, -128. Rerun with SHIFT=2: outputs 50, -128 (-250 saturated), 31, -32.
- Backpressure. Setup: out_ready toggles 1,0,0,1,... Required: out_data/row/col remain stable while out_valid && !out_ready; no element skipped or duplicated; exactly 4 handshakes.
- Held done and overrun. Setup: done stays high for 20 cycles. Required: exactly one drain. Setup: drop done, then raise it again mid-stream. Required: overrun=1 and sticky; the stream continues with the original snapshot values even if acc_in changes after capture.
- Reset mid-stream. Setup: assert reset after 2 handshakes. Required: all outputs 0 on the next cycle. Setup: raise done again. Required: a full 4-element drain starting at (0,0).
- N=1 / N=4. Setup: N=1 with a single element. Required: out_last on the first valid. Setup: N=4 with acc_in(r,c)=r*4+c and ready high. Required: sequence 0..15 in row-major order, drain_done 16 cycles after the first valid.
